perceptron_sample_loader: RTL and testbench
===========================================

// Module: perceptron_sample_loader
// PURPOSE
//  Producer side of the perceptron sample interface: parses a byte stream of training frames into
//  (x0,x1,y) samples and hands them to the perceptron core over a valid/ready port.
//  Sits between the tt_um pin bytes and the training datapath; 4-bit features, 1-bit label.
//  Buffers parsed samples in a small FIFO so the core can stall training without losing input.
// PARAMETERS
//  FEAT_W       4   width of each feature x0/x1 (packed two per byte; FEAT_W*2 must equal 8)
//  DEPTH        4   sample FIFO entries (power of 2, >=2)
//  MAX_SAMPLES  15  largest legal sample count in a frame header
// PORTS
//  clk         in   1        clock; all logic rising-edge
//  rst         in   1        reset, synchronous, active-high
//  in_byte     in   8        stream byte
//  in_valid    in   1        in_byte valid
//  in_ready    out  1        loader accepts in_byte this cycle
//  s_x0        out  FEAT_W   sample feature 0
//  s_x1        out  FEAT_W   sample feature 1
//  s_y         out  1        sample label
//  s_last      out  1        sample is last of its frame
//  s_valid     out  1        sample presented
//  s_ready     in   1        core consumes sample
//  frame_done  out  1        1-cycle pulse: frame fully parsed without error
//  frame_err   out  1        1-cycle pulse: frame aborted
//  busy        out  1        FSM not in IDLE or FIFO not empty
// BEHAVIOUR
//  Frame: 0xA5 (SOF), N (1..MAX_SAMPLES), then N x {X byte={x1,x0}, Y byte={7'b0,y}} [, CSUM].
//  Byte transfer on in_valid&in_ready; sample transfer on s_valid&s_ready.
//  FSM: IDLE -> CNT -> XB -> YB -> (XB | CSUM | IDLE) ; any error -> IDLE.
//  IDLE: non-SOF bytes consumed and dropped silently; SOF -> CNT.
//  CNT: N==0 or N>MAX_SAMPLES -> frame_err, IDLE; else load remaining counter, -> XB.
//  XB: latch x0=byte[3:0], x1=byte[7:4] -> YB.
//  YB: byte[7:1]!=0 -> frame_err, IDLE, sample not pushed; else push {last,y,x1,x0}.
//  in_ready=0 only in YB while FIFO full; 1 in all other states (no push/pop pass-through).
//  Latency: sample on s_valid the cycle after its Y byte handshake; FIFO is show-ahead, in order.
//  frame_done/frame_err asserted the cycle after the terminating byte handshake; never both.
//  Samples already pushed before an error stay in FIFO; core discards frame on frame_err.
//  Reset mid-frame: FSM->IDLE, FIFO flushed, counter cleared.
//  Reset values: in_ready=1, s_valid=0, s_x0/s_x1/s_y/s_last=0, frame_done=0, frame_err=0, busy=0.
// CONFIGURATION
//  PERCEPTRON_LOADER_CHECKSUM_EN defined: after last Y byte FSM -> CSUM; expects XOR of all bytes
//   after SOF (N..last Y); match -> frame_done, mismatch -> frame_err. Samples still stream early.
//  Undefined: no CSUM state; frame_done follows last Y byte.
// STRUCTURE
//  perceptron_pkg: SOF_BYTE=8'hA5, loader state enum, sample struct {last,y,x1,x0}.
//  Sub-module perceptron_sample_fifo: DEPTH-entry sync FIFO, show-ahead, full/empty flags.
// TESTING
//  Reset: rst=1 two cycles -> in_ready=1, s_valid=0, busy=0, no pulses.
//  A5,02,32,00,54,01, s_ready=1 -> (2,3,0,last0) then (4,5,1,last1); frame_done pulse once.
//  s_ready=0, N=6 frame -> in_ready low in 5th YB; raise s_ready -> all 6 in order, last on 6th.
//  A5,01,32,02 -> frame_err pulse, no sample; then A5,00 -> frame_err; A5,10 -> frame_err.
//  CHECKSUM_EN: A5,01,32,01,32 -> sample+frame_done; last byte 33 -> sample+frame_err.
//  rst mid-frame after A5,02,32 -> IDLE, FIFO empty; next good frame parses correctly.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types for the perceptron sample loader: SOF marker, loader FSM states, sample record.
// PERCEPTRON_LOADER_CHECKSUM_EN adds the trailing-checksum state to the loader enum.
package perceptron_pkg;

  localparam logic [7:0]  SOF_BYTE      = 8'hA5;
  localparam int unsigned SAMPLE_FEAT_W = 4;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_CNT,
    LD_XB,
    LD_YB
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    ,
    LD_CSUM
`endif
  } loader_state_e;

  typedef struct packed {
    logic                     last;
    logic                     y;
    logic [SAMPLE_FEAT_W-1:0] x1;
    logic [SAMPLE_FEAT_W-1:0] x0;
  } sample_t;

  localparam int unsigned SAMPLE_W = $bits(sample_t);

  // X byte carries {x1,x0}; only bit 0 of the Y byte is the label.
  function automatic sample_t make_sample(input logic last, input logic y,
                                          input logic [7:0] xbyte);
    sample_t s;
    s.last = last;
    s.y    = y;
    s.x1   = xbyte[7:4];
    s.x0   = xbyte[3:0];
    return s;
  endfunction

endpackage

// File: rtl/perceptron_sample_fifo.sv
// Show-ahead synchronous FIFO holding parsed samples; head entry is visible whenever not empty.
// Pushes while full and pops while empty are ignored.
module perceptron_sample_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      wr_d = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/perceptron_sample_loader.sv
// Parses 0xA5-framed byte streams into (x0,x1,y,last) samples and queues them for the perceptron core.
// Define PERCEPTRON_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module perceptron_sample_loader
  import perceptron_pkg::*;
#(
  parameter int unsigned FEAT_W      = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MAX_SAMPLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FEAT_W-1:0] s_x0,
  output logic [FEAT_W-1:0] s_x1,
  output logic              s_y,
  output logic              s_last,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [7:0] MAX_N = 8'(MAX_SAMPLES);

  loader_state_e state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    xbyte_q, xbyte_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          in_fire;
  logic          push;
  sample_t       push_data;
  logic          pop;
  sample_t       head;
  logic [SAMPLE_W-1:0] head_bits;
  logic          fifo_full;
  logic          fifo_empty;

  perceptron_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Stall only while a Y byte would need a slot; a same-cycle pop does not free it early.
  assign in_ready = !((state_q == LD_YB) && fifo_full);
  assign in_fire  = in_valid && in_ready;

  assign head    = sample_t'(head_bits);
  assign s_valid = !fifo_empty;
  assign pop     = s_valid && s_ready;
  assign s_x0    = fifo_empty ? '0 : head.x0;
  assign s_x1    = fifo_empty ? '0 : head.x1;
  assign s_y     = fifo_empty ? 1'b0 : head.y;
  assign s_last  = fifo_empty ? 1'b0 : head.last;

  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != LD_IDLE) || !fifo_empty;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    xbyte_d   = xbyte_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    push      = 1'b0;
    push_data = make_sample(rem_q == 8'd1, in_byte[0], xbyte_q);
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    if (in_fire) begin
      case (state_q)
        LD_IDLE: begin
          if (in_byte == SOF_BYTE) begin
            state_d = LD_CNT;
          end
        end
        LD_CNT: begin
          if ((in_byte == 8'd0) || (in_byte > MAX_N)) begin
            err_d   = 1'b1;
            state_d = LD_IDLE;
          end else begin
            rem_d   = in_byte;
            state_d = LD_XB;
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
            csum_d  = in_byte;
`endif
          end
        end
        LD_XB: begin
          xbyte_d = in_byte;
          state_d = LD_YB;
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_byte;
`endif
        end
        LD_YB: begin
          if (in_byte[7:1] != 7'd0) begin
            err_d   = 1'b1;
            state_d = LD_IDLE;
          end else begin
            push  = 1'b1;
            rem_d = rem_q - 8'd1;
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ in_byte;
`endif
            if (rem_q == 8'd1) begin
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
              state_d = LD_CSUM;
`else
              done_d  = 1'b1;
              state_d = LD_IDLE;
`endif
            end else begin
              state_d = LD_XB;
            end
          end
        end
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
        LD_CSUM: begin
          if (in_byte == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = LD_IDLE;
        end
`endif
        default: begin
          state_d = LD_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      rem_q   <= '0;
      xbyte_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      xbyte_q <= xbyte_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Self-checking bench for perceptron_sample_loader: frame-position reference model plus directed frames.
// Honours PERCEPTRON_LOADER_CHECKSUM_EN the same way as the design.
module tb_perceptron_sample_loader;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] s_x0;
  logic [3:0] s_x1;
  logic       s_y;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  perceptron_sample_loader #(
    .FEAT_W      (4),
    .DEPTH       (DEPTH),
    .MAX_SAMPLES (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .s_x0       (s_x0),
    .s_x1       (s_x1),
    .s_y        (s_y),
    .s_last     (s_last),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks byte position within the frame, samples as {last,y,x1,x0}.
  bit          armed    = 1'b0;
  bit          in_frame = 1'b0;
  int unsigned idx      = 0;
  int unsigned nsmp     = 0;
  logic [7:0]  xb;
  logic [7:0]  cs;
  logic [9:0]  mq[$];
  bit          exp_done = 1'b0;
  bit          exp_err  = 1'b0;
  logic [9:0]  log_q[$];
  int unsigned done_seen = 0;
  int unsigned err_seen  = 0;
  logic [7:0]  stim[$];

  function automatic bit exp_in_ready();
    bit want_y;
    want_y = in_frame && (idx >= 2) && (idx <= 2 * nsmp) && (idx[0] == 1'b0);
    return !(want_y && (mq.size() >= DEPTH));
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1'b1;
        idx      = 0;
      end
    end else if (idx == 0) begin
      if (b == 8'd0 || b > 8'd15) begin
        exp_err  = 1'b1;
        in_frame = 1'b0;
      end else begin
        nsmp = b;
        cs   = b;
        idx  = 1;
      end
    end else if (idx <= 2 * nsmp) begin
      if (idx[0]) begin
        xb  = b;
        cs  = cs ^ b;
        idx = idx + 1;
      end else if (b[7:1] != 7'd0) begin
        exp_err  = 1'b1;
        in_frame = 1'b0;
      end else begin
        cs = cs ^ b;
        mq.push_back({(idx == 2 * nsmp), b[0], xb[7:4], xb[3:0]});
        if (idx == 2 * nsmp) begin
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
          idx = idx + 1;
`else
          exp_done = 1'b1;
          in_frame = 1'b0;
`endif
        end else begin
          idx = idx + 1;
        end
      end
    end else begin
      if (b == cs) exp_done = 1'b1;
      else         exp_err  = 1'b1;
      in_frame = 1'b0;
    end
  endtask

  // Compare, then advance the model by the handshakes that the next rising edge will take.
  always begin
    logic [9:0] head;
    bit         ev;
    @(negedge clk);
    #2;
    if (armed) begin
      ev   = (mq.size() != 0);
      head = ev ? mq[0] : 10'd0;
      chk("s_valid", s_valid, ev);
      chk("s_x0", s_x0, head[3:0]);
      chk("s_x1", s_x1, head[7:4]);
      chk("s_y", s_y, head[8]);
      chk("s_last", s_last, head[9]);
      chk("frame_done", frame_done, exp_done);
      chk("frame_err", frame_err, exp_err);
      chk("in_ready", in_ready, exp_in_ready());
      chk("busy", busy, in_frame || (mq.size() != 0));
    end
    if (frame_done === 1'b1) done_seen++;
    if (frame_err === 1'b1)  err_seen++;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (rst) begin
      armed    = 1'b1;
      in_frame = 1'b0;
      idx      = 0;
      mq.delete();
    end else begin
      if (s_valid && s_ready) begin
        log_q.push_back({s_last, s_y, s_x1, s_x0});
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if (in_valid && in_ready) model_byte(in_byte);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned t;
    t        = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_stim();
    foreach (stim[i]) send_byte(stim[i]);
  endtask

  task automatic clear_obs();
    log_q.delete();
    done_seen = 0;
    err_seen  = 0;
  endtask

  task automatic drain(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] xv;
    logic [7:0] sum;
    rst      = 1'b1;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    s_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {frame_done, frame_err}, 2'b00);
    chk("rst_sample", {s_last, s_y, s_x1, s_x0}, 10'd0);
    rst = 1'b0;

    // Two-sample frame, core always ready.
    s_ready = 1'b1;
    clear_obs();
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    stim = '{8'hA5, 8'h02, 8'h32, 8'h00, 8'h54, 8'h01, 8'h65};
`else
    stim = '{8'hA5, 8'h02, 8'h32, 8'h00, 8'h54, 8'h01};
`endif
    send_stim();
    drain(6);
    chk("t1_count", log_q.size(), 2);
    chk("t1_s0", log_q[0], 10'h032);
    chk("t1_s1", log_q[1], 10'h354);
    chk("t1_done", done_seen, 1);
    chk("t1_err", err_seen, 0);

    // Six-sample frame against a stalled core: fifth Y byte must wait.
    s_ready = 1'b0;
    clear_obs();
    sum  = 8'h06;
    stim = '{8'hA5, 8'h06};
    for (int i = 0; i < 5; i++) begin
      xv = {4'(15 - i), 4'(i + 1)};
      stim.push_back(xv);
      sum = sum ^ xv;
      if (i < 4) begin
        stim.push_back({7'd0, i[0]});
        sum = sum ^ {7'd0, i[0]};
      end
    end
    send_stim();
    chk("t3_in_ready_low", in_ready, 1'b0);
    chk("t3_busy", busy, 1'b1);
    drain(3);
    chk("t3_still_low", in_ready, 1'b0);
    s_ready = 1'b1;
    stim.delete();
    for (int i = 4; i < 6; i++) begin
      xv = {4'(15 - i), 4'(i + 1)};
      if (i == 5) begin
        stim.push_back(xv);
        sum = sum ^ xv;
      end
      stim.push_back({7'd0, i[0]});
      sum = sum ^ {7'd0, i[0]};
    end
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    stim.push_back(sum);
`endif
    send_stim();
    drain(8);
    chk("t3_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) chk("t3_sample", log_q[i], {(i == 5), i[0], 4'(15 - i), 4'(i + 1)});
    end
    chk("t3_done", done_seen, 1);

    // Malformed frames: bad Y byte, zero count, over-limit count.
    clear_obs();
    stim = '{8'hA5, 8'h01, 8'h32, 8'h02, 8'hA5, 8'h00, 8'hA5, 8'h10};
    send_stim();
    drain(4);
    chk("t4_err", err_seen, 3);
    chk("t4_done", done_seen, 0);
    chk("t4_count", log_q.size(), 0);

`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    clear_obs();
    stim = '{8'hA5, 8'h01, 8'h32, 8'h01, 8'h32, 8'hA5, 8'h01, 8'h32, 8'h01, 8'h33};
    send_stim();
    drain(4);
    chk("t5_count", log_q.size(), 2);
    chk("t5_s0", log_q[0], 10'h332);
    chk("t5_s1", log_q[1], 10'h332);
    chk("t5_done", done_seen, 1);
    chk("t5_err", err_seen, 1);
`endif

    // Reset in the middle of a frame, then a clean frame.
    clear_obs();
    s_ready = 1'b0;
    stim    = '{8'hA5, 8'h02, 8'h32};
    send_stim();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_s_valid", s_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    s_ready = 1'b1;
`ifdef PERCEPTRON_LOADER_CHECKSUM_EN
    stim = '{8'hA5, 8'h02, 8'h32, 8'h00, 8'h54, 8'h01, 8'h65};
`else
    stim = '{8'hA5, 8'h02, 8'h32, 8'h00, 8'h54, 8'h01};
`endif
    send_stim();
    drain(6);
    chk("t6_count", log_q.size(), 2);
    chk("t6_s0", log_q[0], 10'h032);
    chk("t6_s1", log_q[1], 10'h354);
    chk("t6_done", done_seen, 1);
    chk("t6_err", err_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
